// File: rtl/div_share_arb_if.sv
// -----------------------------------------------------------------------------
// div_share_arb_if
// Bundles the client request/response signals and the shared divider
// handshake for div_share_arb.
//
// Modports:
//   slave  : the arbiter's view. It receives client requests and divider
//            status, and drives grants, responses and divider operands.
//   master : the environment's view. It is the clients plus the divider,
//            so it drives requests and divider status and receives the rest.
//
// Signal groups (N = number of requesters):
//   req_valid[N], req_mode[N], req_divisor[16*N], req_dividend[32*N]
//   req_ready[N], resp_valid[N], resp_result[32], resp_err
//   div_valid_in, div_mode, div_divisor[16], div_dividend[32]
//   div_busy, div_valid_out, div_result[32]
// -----------------------------------------------------------------------------
interface div_share_arb_if #(
   parameter int N = 4
);
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_mode;
   logic [16*N-1:0]   req_divisor;
   logic [32*N-1:0]   req_dividend;
   logic [N-1:0]      req_ready;
   logic [N-1:0]      resp_valid;
   logic [31:0]       resp_result;
   logic              resp_err;
   logic              div_valid_in;
   logic              div_mode;
   logic [15:0]       div_divisor;
   logic [31:0]       div_dividend;
   logic              div_busy;
   logic              div_valid_out;
   logic [31:0]       div_result;

   modport slave (
      input  req_valid, req_mode, req_divisor, req_dividend,
      input  div_busy, div_valid_out, div_result,
      output req_ready, resp_valid, resp_result, resp_err,
      output div_valid_in, div_mode, div_divisor, div_dividend
   );

   modport master (
      output req_valid, req_mode, req_divisor, req_dividend,
      output div_busy, div_valid_out, div_result,
      input  req_ready, resp_valid, resp_result, resp_err,
      input  div_valid_in, div_mode, div_divisor, div_dividend
   );
endinterface

// File: rtl/div_share_arb.sv
// -----------------------------------------------------------------------------
// div_share_arb
// Round-robin arbiter sharing one divider/modulo unit among N requesters.
// One request is owned at a time: operands are captured, the divider is
// started and waited on, and the result is routed back to the owner. Zero
// divisors are answered immediately with an error, and a watchdog turns a
// stalled divider into an error response.
//
// Ports:
//   clk          : clock, rising edge
//   reset        : asynchronous, active-high
//   bus_if       : div_share_arb_if.slave (requests, responses, divider)
//   dbg_state_o  : current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP)
//
// Handshakes: a client holds req_valid[i] (with operands) until it sees the
// one-cycle req_ready[i] pulse, at which point its operands are captured; a
// response is a one-cycle resp_valid[i] pulse with resp_result/resp_err.
// Toward the divider, div_valid_in stays high until div_busy is seen, and the
// result is taken on the single div_valid_out pulse while waiting.
// -----------------------------------------------------------------------------
module div_share_arb #(
   parameter int N       = 4,
   parameter int TIMEOUT = 200
) (
   input  logic                 clk,
   input  logic                 reset,
   div_share_arb_if.slave       bus_if,
   output logic [1:0]           dbg_state_o
);
   localparam int PW = $clog2(N);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] owner_q, owner_d;
   logic          mode_q, mode_d;
   logic [15:0]   divisor_q, divisor_d;
   logic [31:0]   dividend_q, dividend_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [N-1:0]  req_ready_q, req_ready_d;
   logic [N-1:0]  resp_valid_q, resp_valid_d;
   logic [31:0]   result_q, result_d;
   logic          err_q, err_d;
   logic          div_valid_in_q, div_valid_in_d;

   logic          found;
   logic [PW-1:0] win;
   logic [N-1:0]  win_oh;
   logic [N-1:0]  owner_oh;
   logic [15:0]   win_divisor;
   logic [7:0]    cnt_inc;
   logic          timeout_hit;

   // Round-robin search: the first active requester at or after ptr_q wins.
   always_comb begin
      found = 1'b0;
      win   = ptr_q;
      for (int k = 0; k < N; k++) begin
         if (!found && bus_if.req_valid[(int'(ptr_q) + k) % N]) begin
            found = 1'b1;
            win   = PW'((int'(ptr_q) + k) % N);
         end
      end
   end

   always_comb begin
      win_oh          = '0;
      win_oh[win]     = 1'b1;
      owner_oh        = '0;
      owner_oh[owner_q] = 1'b1;
   end

   assign win_divisor = bus_if.req_divisor[16*int'(win) +: 16];
   assign cnt_inc     = cnt_q + 8'd1;
   assign timeout_hit = (int'(cnt_inc) >= TIMEOUT);

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      owner_d      = owner_q;
      mode_d       = mode_q;
      divisor_d    = divisor_q;
      dividend_d   = dividend_q;
      cnt_d        = cnt_q;
      req_ready_d  = '0;
      resp_valid_d = '0;
      result_d     = result_q;
      err_d        = err_q;

      case (state_q)
         IDLE: begin
            if (found) begin
               owner_d     = win;
               mode_d      = bus_if.req_mode[win];
               divisor_d   = win_divisor;
               dividend_d  = bus_if.req_dividend[32*int'(win) +: 32];
               ptr_d       = (int'(win) == N-1) ? '0 : win + PW'(1);
               req_ready_d = win_oh;
               cnt_d       = '0;
               if (win_divisor == 16'd0) begin
                  // Answered without touching the divider; the response
                  // pulse lands in the same cycle as req_ready.
                  state_d      = RESP;
                  resp_valid_d = win_oh;
                  result_d     = 32'hFFFF_FFFF;
                  err_d        = 1'b1;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            // div_busy outranks a coincident div_valid_out here; the
            // result pulse is only trusted once the start was accepted.
            if (bus_if.div_busy) begin
               state_d = WAIT;
               cnt_d   = cnt_inc;
            end else if (timeout_hit) begin
               state_d      = RESP;
               resp_valid_d = owner_oh;
               result_d     = '0;
               err_d        = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         WAIT: begin
            // A result arriving on the timeout cycle still counts.
            if (bus_if.div_valid_out) begin
               state_d      = RESP;
               resp_valid_d = owner_oh;
               result_d     = bus_if.div_result;
               err_d        = 1'b0;
            end else if (timeout_hit) begin
               state_d      = RESP;
               resp_valid_d = owner_oh;
               result_d     = '0;
               err_d        = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      div_valid_in_d = (state_d == ISSUE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         ptr_q          <= '0;
         owner_q        <= '0;
         mode_q         <= 1'b0;
         divisor_q      <= '0;
         dividend_q     <= '0;
         cnt_q          <= '0;
         req_ready_q    <= '0;
         resp_valid_q   <= '0;
         result_q       <= '0;
         err_q          <= 1'b0;
         div_valid_in_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         ptr_q          <= ptr_d;
         owner_q        <= owner_d;
         mode_q         <= mode_d;
         divisor_q      <= divisor_d;
         dividend_q     <= dividend_d;
         cnt_q          <= cnt_d;
         req_ready_q    <= req_ready_d;
         resp_valid_q   <= resp_valid_d;
         result_q       <= result_d;
         err_q          <= err_d;
         div_valid_in_q <= div_valid_in_d;
      end
   end

   // Operands come straight from the owner registers, which only change on
   // a grant in IDLE, so the mode-dependent divider output stays stable.
   assign bus_if.req_ready    = req_ready_q;
   assign bus_if.resp_valid   = resp_valid_q;
   assign bus_if.resp_result  = result_q;
   assign bus_if.resp_err     = err_q;
   assign bus_if.div_valid_in = div_valid_in_q;
   assign bus_if.div_mode     = mode_q;
   assign bus_if.div_divisor  = divisor_q;
   assign bus_if.div_dividend = dividend_q;
   assign dbg_state_o         = state_q;
endmodule

// File: tb/tb_div_share_arb.sv
// -----------------------------------------------------------------------------
// tb_div_share_arb
// Directed bench for div_share_arb. A behavioural divider answers the
// arbiter; expected grants and responses are queued by the stimulus and
// popped by a monitor whenever the DUT pulses req_ready or resp_valid.
// -----------------------------------------------------------------------------
module tb_div_share_arb;
   localparam int N       = 4;
   localparam int TIMEOUT = 200;
   localparam int DIV_LAT = 60;
   localparam int W       = 37;   // {owner one-hot[4], err, result[32]}

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] dbg_state;

   div_share_arb_if #(.N(N)) bus ();

   div_share_arb #(.N(N), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus_if      (bus),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- behavioural divider ----------------
   logic div_hang    = 1'b0;
   logic model_abort = 1'b0;
   logic m_run;
   int   m_cnt;

   assign bus.div_result = (bus.div_divisor == 16'd0) ? 32'hFFFF_FFFF :
                           (bus.div_mode ? (bus.div_dividend % {16'd0, bus.div_divisor})
                                         : (bus.div_dividend / {16'd0, bus.div_divisor}));

   always @(negedge clk) begin
      if (reset || model_abort) begin
         m_run             = 1'b0;
         m_cnt             = 0;
         bus.div_busy      = 1'b0;
         bus.div_valid_out = 1'b0;
      end else begin
         bus.div_valid_out = 1'b0;
         if (m_run) begin
            m_cnt = m_cnt + 1;
            if (!div_hang && m_cnt == DIV_LAT) begin
               bus.div_valid_out = 1'b1;
               bus.div_busy      = 1'b0;
               m_run             = 1'b0;
            end
         end else if (bus.div_valid_in) begin
            m_run        = 1'b1;
            m_cnt        = 0;
            bus.div_busy = 1'b1;
         end
      end
   end

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   logic [3:0]   grant_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   int last_ready_cyc = 0;
   int last_resp_cyc  = 0;
   int div_vin_cnt    = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_note(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   function automatic logic [W-1:0] mk_exp(input int i, input logic err, input logic [31:0] res);
      logic [3:0] oh;
      oh    = '0;
      oh[i] = 1'b1;
      return {oh, err, res};
   endfunction

   // Monitor: compares every grant and response pulse against the queues.
   always @(negedge clk) begin
      logic [W-1:0] e;
      logic [3:0]   g;
      if (!reset) begin
         if (bus.div_valid_in) div_vin_cnt++;
         if (bus.req_ready != '0) begin
            last_ready_cyc = cyc;
            if (grant_q.size() == 0) fail_note("unexpected_grant");
            else begin
               g = grant_q.pop_front();
               check("grant", 64'(bus.req_ready), 64'(g));
            end
         end
         if (bus.resp_valid != '0) begin
            last_resp_cyc = cyc;
            if (exp_q.size() == 0) fail_note("unexpected_resp");
            else begin
               e = exp_q.pop_front();
               check("resp_owner",  64'(bus.resp_valid),  64'(e[36:33]));
               check("resp_err",    64'(bus.resp_err),    64'(e[32]));
               check("resp_result", 64'(bus.resp_result), 64'(e[31:0]));
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_req(input int i, input logic m, input logic [31:0] dvd, input logic [15:0] dvs);
      bus.req_mode[i]                = m;
      bus.req_dividend[32*i +: 32]   = dvd;
      bus.req_divisor[16*i +: 16]    = dvs;
   endtask

   // Single request into an idle arbiter: grant must appear one cycle later.
   task automatic issue_now(input int i, input logic m, input logic [31:0] dvd, input logic [15:0] dvs);
      logic [3:0] oh;
      oh    = '0;
      oh[i] = 1'b1;
      grant_q.push_back(oh);
      set_req(i, m, dvd, dvs);
      bus.req_valid[i] = 1'b1;
      @(negedge clk);
      check("ready_t1", 64'(bus.req_ready[i]), 64'd1);
      if (dvs == 16'd0) check("zero_resp_t1", 64'(bus.resp_valid), 64'(oh));
      else              check("div_valid_in_t1", 64'(bus.div_valid_in), 64'd1);
      bus.req_valid[i] = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int c;
      c = 0;
      while (exp_q.size() != 0 && c < budget) begin
         @(negedge clk);
         c++;
      end
      if (exp_q.size() != 0) begin
         fail_note("response_timeout");
         exp_q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n_grants;
      int cnt0;
      bus.req_valid    = '0;
      bus.req_mode     = '0;
      bus.req_divisor  = '0;
      bus.req_dividend = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);

      // reset state
      check("rst_req_ready",    64'(bus.req_ready),    64'd0);
      check("rst_resp_valid",   64'(bus.resp_valid),   64'd0);
      check("rst_resp_result",  64'(bus.resp_result),  64'd0);
      check("rst_resp_err",     64'(bus.resp_err),     64'd0);
      check("rst_div_valid_in", 64'(bus.div_valid_in), 64'd0);
      check("rst_operands",     64'({bus.div_mode, bus.div_divisor, bus.div_dividend}), 64'd0);
      check("rst_state",        64'(dbg_state),        64'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // single request: quotient then remainder
      exp_q.push_back(mk_exp(0, 1'b0, 32'd14));
      issue_now(0, 1'b0, 32'd100, 16'd7);
      wait_drain(300);
      exp_q.push_back(mk_exp(0, 1'b0, 32'd2));
      issue_now(0, 1'b1, 32'd100, 16'd7);
      wait_drain(300);

      // zero divisor: immediate error, divider untouched
      cnt0 = div_vin_cnt;
      exp_q.push_back(mk_exp(2, 1'b1, 32'hFFFF_FFFF));
      issue_now(2, 1'b0, 32'd55, 16'd0);
      wait_drain(50);
      repeat (5) @(negedge clk);
      check("zero_no_issue", 64'(div_vin_cnt), 64'(cnt0));

      // timeout: divider never answers
      div_hang = 1'b1;
      exp_q.push_back(mk_exp(1, 1'b1, 32'd0));
      issue_now(1, 1'b0, 32'd50, 16'd5);
      wait_drain(TIMEOUT + 50);
      check("timeout_latency", 64'(last_resp_cyc - last_ready_cyc), 64'(TIMEOUT));
      model_abort = 1'b1;
      repeat (2) @(negedge clk);
      model_abort = 1'b0;
      div_hang    = 1'b0;
      @(negedge clk);
      exp_q.push_back(mk_exp(1, 1'b0, 32'd9));
      issue_now(1, 1'b0, 32'd81, 16'd9);
      wait_drain(300);

      // hold check: operands changed after capture must not leak through
      exp_q.push_back(mk_exp(1, 1'b0, 32'd100));
      issue_now(1, 1'b0, 32'd1000, 16'd10);
      set_req(1, 1'b1, 32'd7777, 16'd3);
      repeat (10) @(negedge clk);
      check("hold_dividend", 64'(bus.div_dividend), 64'd1000);
      check("hold_divisor",  64'(bus.div_divisor),  64'd10);
      check("hold_mode",     64'(bus.div_mode),     64'd0);
      wait_drain(300);

      // reset in the middle of WAIT: everything clears, no response
      issue_now(3, 1'b0, 32'd100, 16'd7);
      repeat (39) @(negedge clk);
      check("mid_state_wait", 64'(dbg_state), 64'd2);
      reset = 1'b1;
      #1;
      check("mid_rst_resp_valid", 64'(bus.resp_valid),   64'd0);
      check("mid_rst_div_vin",    64'(bus.div_valid_in), 64'd0);
      check("mid_rst_operands",   64'({bus.div_mode, bus.div_divisor, bus.div_dividend}), 64'd0);
      check("mid_rst_result",     64'({bus.resp_err, bus.resp_result}), 64'd0);
      check("mid_rst_state",      64'(dbg_state), 64'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (DIV_LAT + 20) @(negedge clk);
      check("mid_rst_no_pending", 64'(exp_q.size() + grant_q.size()), 64'd0);

      // round-robin from ptr=0 with all four requesting continuously
      set_req(0, 1'b0, 32'd1000,  16'd3);
      set_req(1, 1'b0, 32'd999,   16'd9);
      set_req(2, 1'b0, 32'd5000,  16'd7);
      set_req(3, 1'b0, 32'd65536, 16'd256);
      grant_q.push_back(4'b0001);
      grant_q.push_back(4'b0010);
      grant_q.push_back(4'b0100);
      grant_q.push_back(4'b1000);
      grant_q.push_back(4'b0001);
      exp_q.push_back(mk_exp(0, 1'b0, 32'd333));
      exp_q.push_back(mk_exp(1, 1'b0, 32'd111));
      exp_q.push_back(mk_exp(2, 1'b0, 32'd714));
      exp_q.push_back(mk_exp(3, 1'b0, 32'd256));
      exp_q.push_back(mk_exp(0, 1'b0, 32'd333));
      bus.req_valid = 4'hF;
      n_grants = 0;
      for (int c = 0; c < 2000 && n_grants < 5; c++) begin
         @(negedge clk);
         if (bus.req_ready != '0) n_grants++;
      end
      bus.req_valid = '0;
      if (n_grants < 5) fail_note("rr_grant_timeout");
      wait_drain(400);

      check("final_queues_empty", 64'(exp_q.size() + grant_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global guard so the run always ends.
   initial begin
      #2000000;
      $display("FAIL global_timeout (t=%0t)", $time);
      $fatal(1, "global timeout");
   end
endmodule

// File: doc/div_share_arb.md
# div_share_arb

Round-robin arbiter that shares one non-restoring divider/modulo unit among N requesters. It captures one request at a time, sequences the divider through its valid/busy/valid_out handshake and returns the result to the owning requester. It also screens out zero divisors and enforces a watchdog timeout. It sits between the client blocks and the divider datapath; the divider is never driven directly by clients.

## Interface
- N, 4: number of requesters (2..8).
- TIMEOUT, 200: max cycles from issue to div_valid_out before error (≤255; nominal divider latency ≈97).
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  N  per-requester request, level; held until req_ready.
- req_mode  in  N  per-requester mode: 0 quotient, 1 remainder.
- req_divisor  in  16*N  divisor, slice i = [16i+15:16i].
- req_dividend  in  32*N  dividend, slice i = [32i+31:32i].
- req_ready  out  N  one-cycle pulse: request i accepted, operands captured.
- resp_valid  out  N  one-cycle pulse: response for requester i.
- resp_result  out  32  result, valid while any resp_valid bit is set.
- resp_err  out  1  qualifies resp_valid: divide-by-zero or timeout.
- div_valid_in  out  1  start request to divider.
- div_mode, div_divisor, div_dividend  out  1/16/32  registered operands to divider.
- div_busy  in  1  divider has accepted the start.
- div_valid_out  in  1  divider result pulse.
- div_result  in  32  divider result (combinational on div_mode).

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any req_valid, pick the winner round-robin starting at pointer ptr (reset 0). Latch mode and operands into owner registers and set owner=i. Pointer becomes (i+1) mod N. Pulse req_ready[i] next cycle.
  - Zero divisor (divisor==0): go to RESP with err=1 and result=32'hFFFF_FFFF. Divider is not issued.
  - Otherwise go to ISSUE.
- ISSUE: div_valid_in=1. Stay until div_busy==1, then go to WAIT (div_valid_in low from that cycle on).
- WAIT: on div_valid_out==1, register div_result and go to RESP with err=0.
- Timeout: counter clears on entry to ISSUE and increments each ISSUE/WAIT cycle. On reaching TIMEOUT, go to RESP with err=1 and result=0.
- RESP: resp_valid[owner]=1, resp_result and resp_err driven from registers. Always returns to IDLE next cycle.
- div_mode, div_divisor and div_dividend hold the owner registers stable from ISSUE through the WAIT exit. The divider output is mode-dependent, so these must not change before capture.
- Non-owner requests are ignored until IDLE. Requests that drop before grant are lost silently.
- A request with req_valid held after req_ready is treated as a new request.

## Timing
- Reset values: req_ready=0, resp_valid=0, resp_result=0, resp_err=0, div_valid_in=0, operands=0, ptr=0, state=IDLE, counter=0.
- Request sampled at clock edge t in IDLE, then:
  - req_ready pulse in cycle t+1.
  - div_valid_in high from t+1.
  - Zero-divisor response in cycle t+1.
- div_valid_out seen at edge u: resp_valid in cycle u+1 (1-cycle pulse). IDLE at u+2, so a new grant is possible at edge u+2.
- Back-to-back service: at least 3 non-divider cycles of overhead per transaction.
- div_busy and div_valid_out arriving together in ISSUE: div_busy takes priority, go to WAIT. div_valid_out is only honored in WAIT.
- Timeout and div_valid_out in the same WAIT cycle: result wins, err=0.
- All outputs are registered; no combinational path from req_* to div_*.
- reset mid-transaction: abort immediately to reset values, with no response to the owner. The divider shares the reset.

## Test plan
- Single request: r0, 100/7, mode 0 → req_ready[0] at t+1, then resp_valid[0] with result 14, err 0. Repeat with mode 1 → result 2.
- Round-robin: all four requesting continuously with distinct operands → grants in order 0,1,2,3,0. Each response is routed to the correct resp_valid bit with correct quotient.
- Zero divisor: r2, 55/0 → resp_valid[2] at t+1, result 32'hFFFF_FFFF, err 1. div_valid_in never asserted.
- Timeout: divider model never asserts div_valid_out → resp_err=1, result 0 exactly TIMEOUT cycles after ISSUE entry; next request is served normally.
- Reset mid-WAIT: assert reset 40 cycles into a transaction → all outputs 0 at once and no resp_valid. After release, a new request completes correctly with ptr=0.
- Hold check: change req_* operands after req_ready → div_* outputs and result unaffected (1000/10 → 100).
